updown_mod_counter: RTL and testbench

- Parametrised synchronous up/down counter; next generation of the lab's N-bit up/down counter.
- Adds a programmable modulus, count enable, synchronous clear, parallel load, wrap/saturate mode, a terminal-count flag and a registered wrap/saturate event pulse.
- Used as a building block for timers, dividers and sequencers in later labs. Everything is clocked on the clk rising edge.

---
 rtl/counter_pkg.sv | 17 +
 rtl/updown_mod_next.sv | 49 ++++
 rtl/updown_mod_counter.sv | 62 ++++++
 tb/tb_updown_mod_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulus counter family.
// Mode/direction encodings and the load clamp live here so every user agrees on them.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Out-of-range load values pin to the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] modulus);
    return (val < modulus) ? val : (modulus - 32'd1);
  endfunction

endpackage

// File: rtl/updown_mod_next.sv
// Combinational next-count and event generator for updown_mod_counter.
// Priority is clr, then load, then the enabled step.
module updown_mod_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             en,
  input  logic             up_down,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic             evt_nxt
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  always_comb begin
    cnt_nxt = cnt;
    evt_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
    end else if (en) begin
      if (up_down == DIR_UP) begin
        if (cnt == CNT_MAX) begin
          evt_nxt = 1'b1;
          cnt_nxt = (SATURATE == CNT_SAT) ? cnt : '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end else begin
        if (cnt == '0) begin
          evt_nxt = 1'b1;
          cnt_nxt = (SATURATE == CNT_SAT) ? cnt : CNT_MAX;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate mode,
// terminal-count flag and a registered boundary-event pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_down,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             evt
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  logic [WIDTH-1:0] cnt_nxt;
  logic             evt_nxt;

  updown_mod_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .cnt     (cnt),
    .en      (en),
    .up_down (up_down),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .cnt_nxt (cnt_nxt),
    .evt_nxt (evt_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      evt <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      evt <= evt_nxt;
    end
  end

  assign tc = en & (((up_down == DIR_UP) & (cnt == CNT_MAX)) |
                    ((up_down == DIR_DOWN) & (cnt == '0)));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed plus random checks of three counter configurations against an
// arithmetic reference model: mod-10 wrap, mod-10 saturate, full-range mod-16 wrap.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up_down = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_w, cnt_s, cnt_f;
  logic       tc_w, tc_s, tc_f, evt_w, evt_s, evt_f;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_w), .tc(tc_w), .evt(evt_w));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_s), .tc(tc_s), .evt(evt_s));
  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_f), .tc(tc_f), .evt(evt_f));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: modular arithmetic on plain integers.
  function automatic int model_step(input int m, input int modulus, input bit sat,
                                    output bit e);
    int lv;
    e = 1'b0;
    lv = int'(load_val);
    if (clr) return 0;
    if (load) return (lv < modulus) ? lv : modulus - 1;
    if (!en) return m;
    if (up_down) begin
      e = (m + 1 == modulus);
      return (e && sat) ? m : (m + 1) % modulus;
    end
    e = (m == 0);
    return (e && sat) ? m : (m - 1 + modulus) % modulus;
  endfunction

  function automatic bit model_tc(input int m, input int modulus);
    return en && ((up_down && m == modulus - 1) || (!up_down && m == 0));
  endfunction

  int mw = 0, ms = 0, mf = 0;
  bit ew = 1'b0, es = 1'b0, ef = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit e1, e2, e3;
    int n1, n2, n3;
    if (!rst_n) begin
      mw <= 0; ms <= 0; mf <= 0;
      ew <= 1'b0; es <= 1'b0; ef <= 1'b0;
    end else begin
      n1 = model_step(mw, 10, 1'b0, e1);
      n2 = model_step(ms, 10, 1'b1, e2);
      n3 = model_step(mf, 16, 1'b0, e3);
      mw <= n1; ms <= n2; mf <= n3;
      ew <= e1; es <= e2; ef <= e3;
    end
  end

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("w_cnt", int'(cnt_w), mw);
      chk("w_evt", int'(evt_w), int'(ew));
      chk("w_tc",  int'(tc_w),  int'(model_tc(mw, 10)));
      chk("s_cnt", int'(cnt_s), ms);
      chk("s_evt", int'(evt_s), int'(es));
      chk("s_tc",  int'(tc_s),  int'(model_tc(ms, 10)));
      chk("f_cnt", int'(cnt_f), mf);
      chk("f_evt", int'(evt_f), int'(ef));
      chk("f_tc",  int'(tc_f),  int'(model_tc(mf, 16)));
    end
  end

  initial begin
    int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_dn[4]  = '{1, 0, 9, 8};
    int exp_sat[5] = '{8, 9, 9, 9, 9};

    // reset, then count up through the mod-10 wrap
    repeat (2) @(negedge clk);
    chk("reset_cnt_w", int'(cnt_w), 0);
    chk("reset_evt_w", int'(evt_w), 0);
    #1 rst_n = 1'b1; en = 1'b1; up_down = 1'b1; chk_on = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("up_cnt", int'(cnt_w), exp_up[k-1]);
      chk("up_evt", int'(evt_w), (k == 10) ? 1 : 0);
      if (k == 9) begin
        chk("up_tc9", int'(tc_w), 1);
        chk("model_pin_9", mw, 9);
      end
    end

    // load 2, count down through the wrap to 9
    #1 load = 1'b1; load_val = 4'd2;
    @(negedge clk);
    chk("load2", int'(cnt_w), 2);
    #1 load = 1'b0; up_down = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("dn_cnt", int'(cnt_w), exp_dn[k-1]);
      chk("dn_evt", int'(evt_w), (k == 3) ? 1 : 0);
      if (k == 2) chk("dn_tc0", int'(tc_w), 1);
    end

    // saturate: up from 7 sticks at 9, then one step down
    #1 load = 1'b1; load_val = 4'd7; up_down = 1'b1;
    @(negedge clk);
    chk("sat_load7", int'(cnt_s), 7);
    #1 load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("sat_cnt", int'(cnt_s), exp_sat[k-1]);
      chk("sat_evt", int'(evt_s), (k >= 3) ? 1 : 0);
    end
    chk("model_pin_sat", ms, 9);
    #1 up_down = 1'b0;
    @(negedge clk);
    chk("sat_down", int'(cnt_s), 8);
    chk("sat_down_evt", int'(evt_s), 0);

    // clamp, priority, hold
    #1 load = 1'b1; load_val = 4'd13;
    @(negedge clk);
    chk("clamp_w", int'(cnt_w), 9);
    chk("clamp_f", int'(cnt_f), 13);
    #1 clr = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("clr_prio_w", int'(cnt_w), 0);
    chk("clr_prio_f", int'(cnt_f), 0);
    #1 clr = 1'b0; load_val = 4'd5;
    @(negedge clk);
    #1 load = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_cnt", int'(cnt_w), 5);
      chk("hold_evt", int'(evt_w), 0);
      chk("hold_tc",  int'(tc_w), 0);
    end

    // asynchronous reset between edges at cnt=6
    #1 load = 1'b1; load_val = 4'd6;
    @(negedge clk);
    chk("pre_rst6", int'(cnt_w), 6);
    #1 load = 1'b0; rst_n = 1'b0;
    #2;
    chk("async_cnt_w", int'(cnt_w), 0);
    chk("async_evt_w", int'(evt_w), 0);
    @(negedge clk);
    #1 rst_n = 1'b1; en = 1'b1; up_down = 1'b1;
    @(negedge clk);
    chk("post_rst_up", int'(cnt_w), 1);

    // full range: 0 down to 15, 15 up to 0, then reset while evt is high
    #1 load = 1'b1; load_val = 4'd0; up_down = 1'b0;
    @(negedge clk);
    chk("f_load0", int'(cnt_f), 0);
    #1 load = 1'b0;
    @(negedge clk);
    chk("f_dn_wrap", int'(cnt_f), 15);
    chk("f_dn_evt", int'(evt_f), 1);
    #1 up_down = 1'b1;
    @(negedge clk);
    chk("f_up_wrap", int'(cnt_f), 0);
    chk("f_up_evt", int'(evt_f), 1);
    chk("model_pin_f", mf, 0);
    #1 rst_n = 1'b0;
    #2;
    chk("async_evt_f", int'(evt_f), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // random traffic, checked every cycle by the compare process
    for (int i = 0; i < 200; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_down  = $urandom_range(0, 1) != 0;
      load     = ($urandom_range(0, 9) == 0);
      clr      = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      @(negedge clk);
      #1;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
